// File: rtl/led_rx_decoder.sv
// Serial LED-tape receiver: pulse-width decoder to 24-bit words with frame-latch detection.
// Strobes registered, word out at falling-edge cycle + 1; no backpressure, output is fire-and-forget.
module led_rx_decoder #(
  parameter int T_MIN_HIGH = 4,
  parameter int T_SPLIT    = 30,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic [15:0] num,
  output logic        frame_end,
  output logic        err
);

  localparam logic [15:0] MIN_W = 16'(T_MIN_HIGH);
  localparam logic [15:0] SPL_W = 16'(T_SPLIT);
  localparam logic [15:0] MAX_W = 16'(T_MAX_HIGH);
  localparam logic [15:0] RST_W = 16'(T_RESET);

  typedef enum logic [1:0] {SYNC, LOW, HIGH, ERR} state_t;

  state_t      state_q, state_d;
  logic        din_m_q, din_m_d;
  logic        din_s_q, din_s_d;
  logic        din_d_q, din_d_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [15:0] widx_q, widx_d;
  logic [23:0] shift_q, shift_d;
  logic        dirty_q, dirty_d;
  logic [23:0] rgb_q, rgb_d;
  logic [15:0] num_q, num_d;
  logic        rgb_valid_q, rgb_valid_d;
  logic        frame_end_q, frame_end_d;
  logic        err_q, err_d;

  logic        rise;
  logic        bit_val;
  logic [23:0] shift_nxt;

  assign rise      = din_s_q & ~din_d_q;
  assign bit_val   = (hcnt_q >= SPL_W);
  assign shift_nxt = {bit_val, shift_q[23:1]};

  always_comb begin
    state_d     = state_q;
    din_m_d     = din;
    din_s_d     = din_m_q;
    din_d_d     = din_s_q;
    lcnt_d      = lcnt_q;
    hcnt_d      = hcnt_q;
    bcnt_d      = bcnt_q;
    widx_d      = widx_q;
    shift_d     = shift_q;
    dirty_d     = dirty_q;
    rgb_d       = rgb_q;
    num_d       = num_q;
    rgb_valid_d = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      SYNC: begin
        // Entering LOW here starts a clean frame but is silent: nothing was received to latch.
        if (din_s_q) begin
          lcnt_d = 16'd0;
        end else if (lcnt_q + 16'd1 >= RST_W) begin
          lcnt_d  = RST_W;
          state_d = LOW;
          widx_d  = 16'd0;
          bcnt_d  = 5'd0;
          shift_d = 24'd0;
          dirty_d = 1'b0;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = 16'd1;
        end else if (lcnt_q < RST_W) begin
          lcnt_d = lcnt_q + 16'd1;
          if (lcnt_q + 16'd1 == RST_W) begin
            frame_end_d = dirty_q;
            err_d       = (bcnt_q != 5'd0);
            widx_d      = 16'd0;
            bcnt_d      = 5'd0;
            shift_d     = 24'd0;
            dirty_d     = 1'b0;
          end
        end
      end

      HIGH: begin
        if (din_s_q) begin
          if (hcnt_q >= MAX_W) begin
            state_d = ERR;
            err_d   = 1'b1;
            shift_d = 24'd0;
            bcnt_d  = 5'd0;
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end else begin
          state_d = LOW;
          lcnt_d  = 16'd0;
          if (hcnt_q < MIN_W) begin
            err_d = 1'b1;
          end else begin
            shift_d = shift_nxt;
            dirty_d = 1'b1;
            if (bcnt_q == 5'd23) begin
              rgb_d       = shift_nxt;
              num_d       = widx_q;
              rgb_valid_d = 1'b1;
              bcnt_d      = 5'd0;
              widx_d      = (widx_q == 16'hFFFF) ? widx_q : widx_q + 16'd1;
            end else begin
              bcnt_d = bcnt_q + 5'd1;
            end
          end
        end
      end

      ERR: begin
        if (!din_s_q) begin
          state_d = SYNC;
          lcnt_d  = 16'd0;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      din_m_q     <= 1'b0;
      din_s_q     <= 1'b0;
      din_d_q     <= 1'b0;
      lcnt_q      <= 16'd0;
      hcnt_q      <= 16'd0;
      bcnt_q      <= 5'd0;
      widx_q      <= 16'd0;
      shift_q     <= 24'd0;
      dirty_q     <= 1'b0;
      rgb_q       <= 24'd0;
      num_q       <= 16'd0;
      rgb_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_m_q     <= din_m_d;
      din_s_q     <= din_s_d;
      din_d_q     <= din_d_d;
      lcnt_q      <= lcnt_d;
      hcnt_q      <= hcnt_d;
      bcnt_q      <= bcnt_d;
      widx_q      <= widx_d;
      shift_q     <= shift_d;
      dirty_q     <= dirty_d;
      rgb_q       <= rgb_d;
      num_q       <= num_d;
      rgb_valid_q <= rgb_valid_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  assign rgb       = rgb_q;
  assign num       = num_q;
  assign rgb_valid = rgb_valid_q;
  assign frame_end = frame_end_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_rx_decoder.sv
// Scoreboarded bench for led_rx_decoder: directed pulse trains, expected strobes queued ahead of stimulus.
module tb_led_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic [15:0] num;
  logic        frame_end;
  logic        err;

  always #5 clk = ~clk;

  led_rx_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .rgb       (rgb),
    .rgb_valid (rgb_valid),
    .num       (num),
    .frame_end (frame_end),
    .err       (err)
  );

  typedef struct packed {
    logic        vld;
    logic        fe;
    logic        er;
    logic [23:0] rgb;
    logic [15:0] num;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic v, input logic fe, input logic er,
                         input logic [23:0] r, input logic [15:0] n);
    ev_t e;
    e.vld = v; e.fe = fe; e.er = er; e.rgb = r; e.num = n;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    repeat (b ? 45 : 15) @(negedge clk);
    din = 1'b0;
    repeat (b ? 15 : 45) @(negedge clk);
  endtask

  task automatic send_range(input logic [23:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(w[i]);
  endtask

  task automatic glitch(input int hi_cycles);
    din = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    din = 1'b0;
  endtask

  // Any strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rgb_valid || frame_end || err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got vld=%b fe=%b err=%b, expected no strobe",
                 rgb_valid, frame_end, err);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobes", 40'({rgb_valid, frame_end, err}), 40'({mon_e.vld, mon_e.fe, mon_e.er}));
        if (mon_e.vld) begin
          check("rgb", 40'(rgb), 40'(mon_e.rgb));
          check("num", 40'(num), 40'(mon_e.num));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", 40'(rgb), 40'h0);
    check("reset_num", 40'(num), 40'h0);
    check("reset_strobes", 40'({rgb_valid, frame_end, err}), 40'h0);
    rst_n = 1'b1;

    // Single word after idle, then latch.
    push_ev(1, 0, 0, 24'h5AC30F, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    idle(2600);
    send_range(24'h5AC30F, 0, 23);
    idle(2600);
    check("hold_rgb", 40'(rgb), 40'h5AC30F);
    check("hold_num", 40'(num), 40'h0);

    // Glitch with nothing received since latch: err only, no repeated frame_end.
    push_ev(0, 0, 1, 24'h0, 16'd0);
    glitch(2);
    idle(2600);

    // Three back-to-back words, latch, then index restarts.
    push_ev(1, 0, 0, 24'h000001, 16'd0);
    push_ev(1, 0, 0, 24'h800000, 16'd1);
    push_ev(1, 0, 0, 24'hFFFFFF, 16'd2);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    push_ev(1, 0, 0, 24'h123456, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    send_range(24'h000001, 0, 23);
    send_range(24'h800000, 0, 23);
    send_range(24'hFFFFFF, 0, 23);
    idle(2600);
    send_range(24'h123456, 0, 23);
    idle(2600);

    // Mid-word glitch is dropped and the word survives.
    push_ev(0, 0, 1, 24'h0, 16'd0);
    push_ev(1, 0, 0, 24'hA5A5A5, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    send_range(24'hA5A5A5, 0, 5);
    glitch(2);
    idle(20);
    send_range(24'hA5A5A5, 6, 23);
    idle(2600);

    // Line stuck high mid-word: single err, resync resets the word index.
    push_ev(1, 0, 0, 24'h3C3C3C, 16'd0);
    push_ev(0, 0, 1, 24'h0, 16'd0);
    push_ev(1, 0, 0, 24'h0F0F0F, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    send_range(24'h3C3C3C, 0, 23);
    send_range(24'h777777, 0, 9);
    glitch(100);
    idle(2600);
    send_range(24'h0F0F0F, 0, 23);
    idle(2600);

    // Frame ends on a partial word: frame_end and err together.
    push_ev(1, 0, 0, 24'hC0FFEE, 16'd0);
    push_ev(0, 1, 1, 24'h0, 16'd0);
    push_ev(1, 0, 0, 24'h654321, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    send_range(24'hC0FFEE, 0, 23);
    send_range(24'hABCDEF, 0, 9);
    idle(2600);
    send_range(24'h654321, 0, 23);
    idle(2600);

    // Reset during bit 12; the word sent right after must not decode.
    push_ev(1, 0, 0, 24'h222222, 16'd0);
    push_ev(0, 1, 0, 24'h0, 16'd0);
    send_range(24'h999999, 0, 11);
    din = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_rgb", 40'(rgb), 40'h0);
    check("midreset_num", 40'(num), 40'h0);
    check("midreset_strobes", 40'({rgb_valid, frame_end, err}), 40'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    din = 1'b0;
    repeat (15) @(negedge clk);
    send_range(24'h111111, 0, 23);
    idle(2600);
    send_range(24'h222222, 0, 23);
    idle(2600);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", 40'(exp_q.size()), 40'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
